// File: rtl/exmem_stage.sv
// -----------------------------------------------------------------------------
// exmem_stage
//
// EX/MEM pipeline register with a small data-memory handshake controller.
//
// While IDLE, every instruction-side hit (ihit) either captures the EX-stage
// results into the output registers or, with flush high, loads a bubble
// (all zeros). A captured load or store moves the stage into MEMWAIT. In that
// state the stage issues dmemREN/dmemWEN and holds mem_busy high to stall
// upstream until dhit completes the access. A captured halt sets a sticky
// HALTED flag that freezes the stage until nRST.
//
// Ports
//   CLK         in   1   clock, rising edge active
//   nRST        in   1   asynchronous active-low reset
//   ihit        in   1   instruction-side hit, qualifies a pipeline advance
//   dhit        in   1   data-side hit, completes the outstanding access
//   flush       in   1   replace the incoming instruction with a bubble
//   aluout_in   in  32   EX result, also the data-memory address
//   rdat2_in    in  32   store data
//   npc_in      in  32   next PC
//   WBctrl_in   in   4   write-back controls (passed through)
//   MEMctrl_in  in   5   [0] read, [1] write, [4:2] passed through
//   wsel_in     in   5   destination register select
//   halt_in     in   1   halt instruction marker
//   *_out       out      registered copies of the matching *_in
//   dmemREN     out  1   data read request (MEMWAIT only)
//   dmemWEN     out  1   data write request (MEMWAIT only)
//   dmemaddr    out 32   = aluout_out
//   dmemstore   out 32   = rdat2_out
//   mem_busy    out  1   upstream stall: access outstanding and not yet hit
// -----------------------------------------------------------------------------
module exmem_stage (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        flush,
  input  logic [31:0] aluout_in,
  input  logic [31:0] rdat2_in,
  input  logic [31:0] npc_in,
  input  logic [3:0]  WBctrl_in,
  input  logic [4:0]  MEMctrl_in,
  input  logic [4:0]  wsel_in,
  input  logic        halt_in,
  output logic [31:0] aluout_out,
  output logic [31:0] rdat2_out,
  output logic [31:0] npc_out,
  output logic [3:0]  WBctrl_out,
  output logic [4:0]  MEMctrl_out,
  output logic [4:0]  wsel_out,
  output logic        halt_out,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  // All registered pipeline fields; a bubble is simply '0.
  typedef struct packed {
    logic [31:0] aluout;
    logic [31:0] rdat2;
    logic [31:0] npc;
    logic [3:0]  wb_ctrl;
    logic [4:0]  mem_ctrl;
    logic [4:0]  wsel;
  } exmem_t;

  state_t state_q;
  state_t next_state;
  exmem_t pipe_q;
  exmem_t pipe_d;
  logic   halted_q;
  logic   capture;
  logic   set_halt;
  logic   mem_req_in;

  assign mem_req_in = MEMctrl_in[0] | MEMctrl_in[1];

  // Incoming field set. A request with both read and write set is a write, so
  // the read bit is cleared here; dmemREN can then follow MEMctrl_out[0]
  // directly.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    pipe_d = '0;
    if (!flush) begin
      pipe_d.aluout   = aluout_in;
      pipe_d.rdat2    = rdat2_in;
      pipe_d.npc      = npc_in;
      pipe_d.wb_ctrl  = WBctrl_in;
      pipe_d.mem_ctrl = {MEMctrl_in[4:2], MEMctrl_in[1], MEMctrl_in[0] & ~MEMctrl_in[1]};
      pipe_d.wsel     = wsel_in;
    end
  end

  // Next-state and capture control.
  always_comb begin
    next_state = state_q;
    capture    = 1'b0;
    set_halt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // dhit here is a spurious hit and is deliberately ignored.
        if (ihit && !halted_q) begin
          capture = 1'b1;
          if (!flush) begin
            // A halt freezes the stage, so it never opens a memory access;
            // entering MEMWAIT while frozen would stall upstream forever.
            if (halt_in) begin
              set_halt = 1'b1;
            end else if (mem_req_in) begin
              next_state = MEMWAIT;
            end
          end
        end
      end
      MEMWAIT: begin
        // ihit and flush are ignored until the access completes.
        if (dhit) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the reset is asynchronous, so the memory strobes (decoded from
  // state_q) drop in the same cycle nRST falls, not at the next edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      pipe_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= next_state;
      if (capture) begin
        pipe_q <= pipe_d;
      end
      if (set_halt) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign aluout_out  = pipe_q.aluout;
  assign rdat2_out   = pipe_q.rdat2;
  assign npc_out     = pipe_q.npc;
  assign WBctrl_out  = pipe_q.wb_ctrl;
  assign MEMctrl_out = pipe_q.mem_ctrl;
  assign wsel_out    = pipe_q.wsel;
  // HALTED is set exactly when halt_out would capture a 1, and both clear only
  // on reset, so the sticky flag doubles as the registered halt output.
  assign halt_out    = halted_q;

  assign dmemREN   = (state_q == MEMWAIT) && pipe_q.mem_ctrl[0];
  assign dmemWEN   = (state_q == MEMWAIT) && pipe_q.mem_ctrl[1];
  assign dmemaddr  = pipe_q.aluout;
  assign dmemstore = pipe_q.rdat2;
  assign mem_busy  = (state_q == MEMWAIT) && !dhit;

  // Structural invariants of the controller.
  a_no_dual_strobe : assert property (@(posedge CLK) disable iff (!nRST)
    !(dmemREN && dmemWEN));
  a_halted_idle : assert property (@(posedge CLK) disable iff (!nRST)
    halted_q |-> (state_q == IDLE));

endmodule

// File: tb/tb_exmem_stage.sv
// -----------------------------------------------------------------------------
// tb_exmem_stage
//
// Directed scoreboard bench for exmem_stage. The stimulus process drives the
// inputs just after each rising edge and pushes the hand-computed output set
// expected during that cycle; a separate monitor pops one entry on every
// falling edge and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_exmem_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, flush, halt_in;
  logic [31:0] aluout_in, rdat2_in, npc_in;
  logic [3:0]  WBctrl_in;
  logic [4:0]  MEMctrl_in, wsel_in;
  logic [31:0] aluout_out, rdat2_out, npc_out, dmemaddr, dmemstore;
  logic [3:0]  WBctrl_out;
  logic [4:0]  MEMctrl_out, wsel_out;
  logic        halt_out, dmemREN, dmemWEN, mem_busy;

  exmem_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .aluout_in(aluout_in), .rdat2_in(rdat2_in), .npc_in(npc_in),
    .WBctrl_in(WBctrl_in), .MEMctrl_in(MEMctrl_in), .wsel_in(wsel_in),
    .halt_in(halt_in),
    .aluout_out(aluout_out), .rdat2_out(rdat2_out), .npc_out(npc_out),
    .WBctrl_out(WBctrl_out), .MEMctrl_out(MEMctrl_out), .wsel_out(wsel_out),
    .halt_out(halt_out), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_busy(mem_busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] alu, rd2, npc;
    logic [3:0]  wb;
    logic [4:0]  mc, ws;
    logic        halt, ren, wen, busy;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", tag, field, act, req);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t m;
      m = q.pop_front();
      check(m.tag, "aluout_out",  aluout_out,         m.alu);
      check(m.tag, "rdat2_out",   rdat2_out,          m.rd2);
      check(m.tag, "npc_out",     npc_out,            m.npc);
      check(m.tag, "WBctrl_out",  32'(WBctrl_out),    32'(m.wb));
      check(m.tag, "MEMctrl_out", 32'(MEMctrl_out),   32'(m.mc));
      check(m.tag, "wsel_out",    32'(wsel_out),      32'(m.ws));
      check(m.tag, "halt_out",    32'(halt_out),      32'(m.halt));
      check(m.tag, "dmemREN",     32'(dmemREN),       32'(m.ren));
      check(m.tag, "dmemWEN",     32'(dmemWEN),       32'(m.wen));
      check(m.tag, "dmemaddr",    dmemaddr,           m.alu);
      check(m.tag, "dmemstore",   dmemstore,          m.rd2);
      check(m.tag, "mem_busy",    32'(mem_busy),      32'(m.busy));
    end
  end

  task automatic set_exp(input logic [31:0] alu, rd2, npc, input logic [3:0] wb,
                         input logic [4:0] mc, ws, input logic halt, ren, wen, busy);
    e.alu = alu; e.rd2 = rd2; e.npc = npc; e.wb = wb; e.mc = mc; e.ws = ws;
    e.halt = halt; e.ren = ren; e.wen = wen; e.busy = busy;
  endtask

  task automatic set_in(input logic [31:0] alu, rd2, npc, input logic [3:0] wb,
                        input logic [4:0] mc, ws, input logic halt);
    aluout_in = alu; rdat2_in = rd2; npc_in = npc; WBctrl_in = wb;
    MEMctrl_in = mc; wsel_in = ws; halt_in = halt;
  endtask

  // Push the expectation for the current cycle, then move past the next edge.
  task automatic cycle(input string tag);
    e.tag = tag;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; flush = 1'b0;
    set_in(32'h0, 32'h0, 32'h0, 4'h0, 5'h0, 5'h0, 1'b0);
    set_exp(32'h0, 32'h0, 32'h0, 4'h0, 5'h0, 5'h0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    cycle("reset");
    nRST = 1'b1;

    // ALU op capture, then hold with ihit low.
    set_in(32'h10, 32'h11, 32'h104, 4'h5, 5'b00000, 5'd3, 1'b0);
    ihit = 1'b1;
    cycle("alu_pre");
    ihit = 1'b0; aluout_in = 32'h99;
    set_exp(32'h10, 32'h11, 32'h104, 4'h5, 5'b00000, 5'd3, 0, 0, 0, 0);
    cycle("alu_cap");
    cycle("alu_hold");

    // Load with three wait cycles.
    set_in(32'h200, 32'h22, 32'h108, 4'hA, 5'b00001, 5'd7, 1'b0);
    ihit = 1'b1;
    cycle("load_pre");
    ihit = 1'b0;
    set_exp(32'h200, 32'h22, 32'h108, 4'hA, 5'b00001, 5'd7, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cycle("load_wait");
    dhit = 1'b1; e.busy = 1'b0;
    cycle("load_hit");
    dhit = 1'b0; e.ren = 1'b0;
    cycle("load_done");

    // Store; ihit/flush pulses during the wait are ignored.
    set_in(32'h300, 32'hDEADBEEF, 32'h10C, 4'h0, 5'b00010, 5'd0, 1'b0);
    ihit = 1'b1;
    cycle("store_pre");
    set_in(32'h555, 32'h55, 32'h1FC, 4'hF, 5'b00001, 5'd9, 1'b0);
    flush = 1'b1;
    set_exp(32'h300, 32'hDEADBEEF, 32'h10C, 4'h0, 5'b00010, 5'd0, 0, 0, 1, 1);
    cycle("store_wait_pulse");
    ihit = 1'b0; flush = 1'b0;
    cycle("store_wait");
    dhit = 1'b1; e.busy = 1'b0;
    cycle("store_hit");
    dhit = 1'b0; e.wen = 1'b0;
    cycle("store_done");

    // Spurious dhit in IDLE changes nothing.
    dhit = 1'b1;
    cycle("spurious_dhit");
    dhit = 1'b0;

    // Read+write together is a write only; upper MEMctrl bits pass through.
    set_in(32'h400, 32'h44, 32'h110, 4'h3, 5'b11111, 5'd12, 1'b0);
    ihit = 1'b1;
    cycle("rw_pre");
    ihit = 1'b0;
    set_exp(32'h400, 32'h44, 32'h110, 4'h3, 5'b11110, 5'd12, 0, 0, 1, 1);
    cycle("rw_wait");
    dhit = 1'b1; e.busy = 1'b0;
    cycle("rw_hit");
    dhit = 1'b0; e.wen = 1'b0;
    cycle("rw_done");

    // Flush together with halt and a memory op: bubble, no halt, no request.
    set_in(32'h500, 32'h55, 32'h114, 4'h7, 5'b00011, 5'd5, 1'b1);
    ihit = 1'b1; flush = 1'b1;
    cycle("flush_pre");
    ihit = 1'b0; flush = 1'b0; halt_in = 1'b0;
    set_exp(32'h0, 32'h0, 32'h0, 4'h0, 5'h0, 5'h0, 0, 0, 0, 0);
    cycle("flush_bubble");
    cycle("flush_idle");
    set_in(32'h600, 32'h66, 32'h200, 4'h1, 5'b00000, 5'd2, 1'b0);
    ihit = 1'b1;
    cycle("after_flush_pre");
    ihit = 1'b0;
    set_exp(32'h600, 32'h66, 32'h200, 4'h1, 5'b00000, 5'd2, 0, 0, 0, 0);
    cycle("after_flush_cap");

    // Halt capture, then frozen despite new captures.
    set_in(32'h700, 32'h77, 32'h300, 4'h3, 5'b00000, 5'd4, 1'b1);
    ihit = 1'b1;
    cycle("halt_pre");
    set_in(32'h800, 32'h88, 32'h304, 4'h9, 5'b00001, 5'd8, 1'b0);
    set_exp(32'h700, 32'h77, 32'h300, 4'h3, 5'b00000, 5'd4, 1, 0, 0, 0);
    cycle("halted");
    cycle("halted_frozen");
    ihit = 1'b0;
    nRST = 1'b0;
    set_exp(32'h0, 32'h0, 32'h0, 4'h0, 5'h0, 5'h0, 0, 0, 0, 0);
    cycle("halt_reset");
    nRST = 1'b1;
    cycle("halt_reset_idle");

    // Reset during MEMWAIT, then a normal capture.
    set_in(32'h900, 32'h99, 32'h400, 4'h2, 5'b00001, 5'd6, 1'b0);
    ihit = 1'b1;
    cycle("rstwait_pre");
    ihit = 1'b0;
    set_exp(32'h900, 32'h99, 32'h400, 4'h2, 5'b00001, 5'd6, 0, 1, 0, 1);
    cycle("rstwait_wait");
    nRST = 1'b0;
    set_exp(32'h0, 32'h0, 32'h0, 4'h0, 5'h0, 5'h0, 0, 0, 0, 0);
    cycle("rstwait_reset");
    nRST = 1'b1;
    set_in(32'hA00, 32'hAA, 32'h500, 4'hC, 5'b00100, 5'd10, 1'b0);
    ihit = 1'b1;
    cycle("rstwait_cap_pre");
    ihit = 1'b0;
    set_exp(32'hA00, 32'hAA, 32'h500, 4'hC, 5'b00100, 5'd10, 0, 0, 0, 0);
    cycle("rstwait_cap");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge CLK);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
